// File: rtl/fp_pkg.sv
// Shared definitions for the sequential floating-point multiplier:
// FSM states, default field widths and canonical special-value encodings.
package fp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MULT,
        ROUND,
        DONE
    } fp_state_t;

    localparam int DEF_EXP_W = 8;
    localparam int DEF_MAN_W = 23;

    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Encodings are built in 64 bits and narrowed by the caller to its word width.
    function automatic logic [63:0] fp_nan(input int exp_w, input int man_w);
        return (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 1));
    endfunction

    function automatic logic [63:0] fp_inf(input logic sign, input int exp_w, input int man_w);
        return ({63'd0, sign} << (exp_w + man_w)) | (((64'd1 << exp_w) - 64'd1) << man_w);
    endfunction

    function automatic logic [63:0] fp_zero(input logic sign, input int exp_w, input int man_w);
        return {63'd0, sign} << (exp_w + man_w);
    endfunction

endpackage

// File: rtl/seq_mantissa_multiplier.sv
// Radix-2 shift-add multiplier: one multiplier bit consumed per cycle, N cycles
// per product. done marks the cycle whose closing edge completes the product.
module seq_mantissa_multiplier #(
    parameter int N = 24
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);

    localparam int CW = $clog2(N + 1);

    logic [N-1:0]   mcand;
    logic [2*N-1:0] acc;
    logic [CW-1:0]  cnt;
    logic [N:0]     sum;

    // Upper half accumulates the partial sum; lower half holds remaining multiplier bits.
    always_comb begin
        sum = {1'b0, acc[2*N-1:N]} + (acc[0] ? {1'b0, mcand} : '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand <= '0;
            acc   <= '0;
            cnt   <= '0;
        end else if (start) begin
            mcand <= a;
            acc   <= {{N{1'b0}}, b};
            cnt   <= CW'(N);
        end else if (cnt != '0) begin
            acc <= {sum, acc[N-1:1]};
            cnt <= cnt - CW'(1);
        end
    end

    assign busy    = (cnt != '0);
    assign done    = (cnt == CW'(1));
    assign product = acc;

endmodule

// File: rtl/fp_mult_seq.sv
// Sequential IEEE-style multiplier with valid/ready handshakes, special-value
// bypass, round-to-nearest-even and flush of subnormal inputs/results to zero.
module fp_mult_seq
    import fp_pkg::*;
#(
    parameter int EXP_W = DEF_EXP_W,
    parameter int MAN_W = DEF_MAN_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   result,
    output logic                   f_nan,
    output logic                   f_inf,
    output logic                   f_ovf,
    output logic                   f_unf
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int N  = MAN_W + 1;
    localparam int EW = EXP_W + 2;
    localparam logic signed [EW-1:0] BIAS    = EW'(fp_bias(EXP_W));
    localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);
    localparam logic [W-1:0]         NAN_WORD = W'(fp_nan(EXP_W, MAN_W));

    fp_state_t state, state_nxt;

    logic             mul_start, mul_busy, mul_done;
    logic [2*N-1:0]   mul_product;

    logic [EXP_W-1:0] a_exp, b_exp;
    logic [MAN_W-1:0] a_frac, b_frac;
    logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic             sign_x, special, spec_nan, spec_inf;
    logic [W-1:0]     spec_word;

    logic                   sign_q;
    logic signed [EW-1:0]   exp_q;

    always_comb begin
        a_exp    = a[W-2:MAN_W];
        b_exp    = b[W-2:MAN_W];
        a_frac   = a[MAN_W-1:0];
        b_frac   = b[MAN_W-1:0];
        a_nan    = (&a_exp) && (|a_frac);
        b_nan    = (&b_exp) && (|b_frac);
        a_inf    = (&a_exp) && !(|a_frac);
        b_inf    = (&b_exp) && !(|b_frac);
        a_zero   = (a_exp == '0);
        b_zero   = (b_exp == '0);
        sign_x   = a[W-1] ^ b[W-1];
        special  = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;
        spec_nan = a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
        spec_inf = !spec_nan && (a_inf | b_inf);
        if (spec_nan)
            spec_word = NAN_WORD;
        else if (spec_inf)
            spec_word = W'(fp_inf(sign_x, EXP_W, MAN_W));
        else
            spec_word = W'(fp_zero(sign_x, EXP_W, MAN_W));
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        mul_start = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    mul_start = !special;
                    state_nxt = special ? DONE : MULT;
                end
            end
            // An idle multiplier here means nothing is in flight; never stall.
            MULT:  if (mul_done || !mul_busy) state_nxt = ROUND;
            ROUND: state_nxt = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    seq_mantissa_multiplier #(
        .N(N)
    ) u_mul (
        .clk    (clk),
        .rst    (rst),
        .start  (mul_start),
        .a      ({1'b1, a_frac}),
        .b      ({1'b1, b_frac}),
        .busy   (mul_busy),
        .done   (mul_done),
        .product(mul_product)
    );

    logic                 msb, guard, sticky, inc, rnd_ovf, rnd_unf;
    logic [2*N-2:0]       norm;
    logic [MAN_W-1:0]     frac_t, frac_r;
    logic [MAN_W+1:0]     sig_r;
    logic signed [EW-1:0] exp_r;
    logic [W-1:0]         rnd_word;

    // Left-align the product so the hidden bit sits just above norm's MSB.
    always_comb begin
        msb     = mul_product[2*N-1];
        norm    = msb ? mul_product[2*N-2:0] : {mul_product[2*N-3:0], 1'b0};
        frac_t  = norm[2*MAN_W -: MAN_W];
        guard   = norm[MAN_W];
        sticky  = |norm[MAN_W-1:0];
        inc     = guard & (sticky | frac_t[0]);
        sig_r   = {2'b01, frac_t} + {{(MAN_W+1){1'b0}}, inc};
        frac_r  = sig_r[MAN_W+1] ? sig_r[MAN_W:1] : sig_r[MAN_W-1:0];
        exp_r   = exp_q + EW'(msb) + EW'(sig_r[MAN_W+1]);
        rnd_ovf = (exp_r >= EXP_MAX);
        rnd_unf = !rnd_ovf && (exp_r[EW-1] || exp_r == '0);
        if (rnd_ovf)
            rnd_word = W'(fp_inf(sign_q, EXP_W, MAN_W));
        else if (rnd_unf)
            rnd_word = W'(fp_zero(sign_q, EXP_W, MAN_W));
        else
            rnd_word = {sign_q, exp_r[EXP_W-1:0], frac_r};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sign_q <= 1'b0;
            exp_q  <= '0;
            result <= '0;
            f_nan  <= 1'b0;
            f_inf  <= 1'b0;
            f_ovf  <= 1'b0;
            f_unf  <= 1'b0;
        end else if (in_valid && in_ready) begin
            sign_q <= sign_x;
            exp_q  <= EW'(a_exp) + EW'(b_exp) - BIAS;
            result <= special ? spec_word : '0;
            f_nan  <= special & spec_nan;
            f_inf  <= special & spec_inf;
            f_ovf  <= 1'b0;
            f_unf  <= 1'b0;
        end else if (state == ROUND) begin
            result <= rnd_word;
            f_nan  <= 1'b0;
            f_inf  <= rnd_ovf;
            f_ovf  <= rnd_ovf;
            f_unf  <= rnd_unf;
        end
    end

endmodule

// File: tb/tb_fp_mult_seq.sv
// Scoreboard bench for fp_mult_seq: default (8/23) and small (5/10) instances,
// directed corner cases plus randomized operands against an arithmetic model.
module tb_fp_mult_seq;

    localparam int E0 = 8;
    localparam int M0 = 23;
    localparam int E1 = 5;
    localparam int M1 = 10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        in_valid0, in_ready0, out_valid0, out_ready0;
    logic [31:0] a0, b0, res0;
    logic        fn0, fi0, fo0, fu0;
    logic        in_valid1, in_ready1, out_valid1, out_ready1;
    logic [15:0] a1, b1, res1;
    logic        fn1, fi1, fo1, fu1;

    fp_mult_seq dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
        .a(a0), .b(b0), .out_valid(out_valid0), .out_ready(out_ready0),
        .result(res0), .f_nan(fn0), .f_inf(fi0), .f_ovf(fo0), .f_unf(fu0)
    );

    fp_mult_seq #(.EXP_W(E1), .MAN_W(M1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .out_valid(out_valid1), .out_ready(out_ready1),
        .result(res1), .f_nan(fn1), .f_inf(fi1), .f_ovf(fo1), .f_unf(fu1)
    );

    typedef struct {
        logic [63:0] res;
        logic [3:0]  fl;
        int          acc;
        int          lat;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   mode0 = 0;
    int   mode1 = 0;
    bit   trk0 = 0;
    bit   trk1 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: exact integer significand product, rounded by remainder comparison.
    function automatic void ref_mul(input logic [63:0] x, input logic [63:0] y,
                                    input int e, input int m, output logic [63:0] r,
                                    output logic [3:0] fl, output bit spc);
        logic [63:0] emax, ea, eb, fa, fb, hid, p, mant, rem, half;
        longint ex;
        bit sg, na, nb, ia, ib, za, zb, top;
        int s;
        emax = (64'd1 << e) - 64'd1;
        sg   = x[e+m] ^ y[e+m];
        ea   = (x >> m) & emax;
        eb   = (y >> m) & emax;
        fa   = x & ((64'd1 << m) - 64'd1);
        fb   = y & ((64'd1 << m) - 64'd1);
        na = (ea == emax) && (fa != 0);
        nb = (eb == emax) && (fb != 0);
        ia = (ea == emax) && (fa == 0);
        ib = (eb == emax) && (fb == 0);
        za = (ea == 0);
        zb = (eb == 0);
        spc = na | nb | ia | ib | za | zb;
        fl  = 4'b0000;
        r   = 64'd0;
        if (na || nb || (ia && zb) || (ib && za)) begin
            r  = (emax << m) | (64'd1 << (m - 1));
            fl = 4'b1000;
        end else if (ia || ib) begin
            r  = (64'(sg) << (e + m)) | (emax << m);
            fl = 4'b0100;
        end else if (za || zb) begin
            r = 64'(sg) << (e + m);
        end else begin
            hid  = 64'd1 << m;
            p    = (hid | fa) * (hid | fb);
            top  = (p >= (64'd1 << (2 * m + 1)));
            s    = m + int'(top);
            mant = p >> s;
            rem  = p - (mant << s);
            half = 64'd1 << (s - 1);
            if (rem > half || (rem == half && mant[0])) mant = mant + 64'd1;
            ex = longint'(ea) + longint'(eb) - longint'((1 << (e - 1)) - 1) + longint'(top);
            if (mant == (hid << 1)) begin
                mant = mant >> 1;
                ex   = ex + 1;
            end
            if (ex >= longint'(emax)) begin
                r  = (64'(sg) << (e + m)) | (emax << m);
                fl = 4'b0110;
            end else if (ex <= 0) begin
                r  = 64'(sg) << (e + m);
                fl = 4'b0001;
            end else begin
                r = (64'(sg) << (e + m)) | (64'(ex) << m) | (mant - hid);
            end
        end
    endfunction

    function automatic logic [63:0] gen(input int e, input int m);
        int bias, r;
        logic [63:0] ex, fr;
        bias = (1 << (e - 1)) - 1;
        r    = int'($urandom_range(0, 11));
        fr   = {$urandom, $urandom} & ((64'd1 << m) - 64'd1);
        case (r)
            0: ex = 64'd0;
            1: ex = (64'd1 << e) - 64'd1;
            2: ex = 64'($urandom_range(0, (1 << e) - 1));
            3: begin ex = (64'd1 << e) - 64'd1; fr = 64'd0; end
            4: begin ex = 64'(bias); fr = fr & ~((64'd1 << (m - 3)) - 64'd1); end
            default: ex = 64'($urandom_range(bias - (bias * 3) / 4, bias + (bias * 3) / 4));
        endcase
        return (64'($urandom_range(0, 1)) << (e + m)) | (ex << m) | fr;
    endfunction

    task automatic send0(input logic [31:0] x, input logic [31:0] y, input logic [63:0] r,
                         input logic [3:0] fl, input int lat);
        exp_t en;
        int n;
        a0 = x;
        b0 = y;
        in_valid0 = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready0 && n < 400);
        if (!in_ready0) begin
            check("accept_timeout0", 64'(in_ready0), 64'd1);
        end else begin
            en.res = r; en.fl = fl; en.acc = cyc + 1; en.lat = lat;
            q0.push_back(en);
        end
        @(posedge clk);
        #1 in_valid0 = 1'b0;
    endtask

    task automatic send1(input logic [15:0] x, input logic [15:0] y, input logic [63:0] r,
                         input logic [3:0] fl, input int lat);
        exp_t en;
        int n;
        a1 = x;
        b1 = y;
        in_valid1 = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready1 && n < 400);
        if (!in_ready1) begin
            check("accept_timeout1", 64'(in_ready1), 64'd1);
        end else begin
            en.res = r; en.fl = fl; en.acc = cyc + 1; en.lat = lat;
            q1.push_back(en);
        end
        @(posedge clk);
        #1 in_valid1 = 1'b0;
    endtask

    task automatic rsend0();
        logic [63:0] x, y, r;
        logic [3:0] fl;
        bit spc;
        x = gen(E0, M0);
        y = gen(E0, M0);
        ref_mul(x, y, E0, M0, r, fl, spc);
        send0(x[31:0], y[31:0], r, fl, spc ? 1 : M0 + 3);
    endtask

    task automatic rsend1();
        logic [63:0] x, y, r;
        logic [3:0] fl;
        bit spc;
        x = gen(E1, M1);
        y = gen(E1, M1);
        ref_mul(x, y, E1, M1, r, fl, spc);
        send1(x[15:0], y[15:0], r, fl, spc ? 1 : M1 + 3);
    endtask

    task automatic drain(input int which);
        int n = 0;
        while (((which == 0) ? q0.size() : q1.size()) != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (which == 0 && q0.size() != 0) check("drain_timeout0", 64'(q0.size()), 64'd0);
        if (which == 1 && q1.size() != 0) check("drain_timeout1", 64'(q1.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            trk0 = 1'b0;
            q0.delete();
        end else if (out_valid0) begin
            if (q0.size() == 0) begin
                check("unexpected_out0", 64'(out_valid0), 64'd0);
            end else begin
                if (!trk0) begin
                    trk0 = 1'b1;
                    check("latency0", 64'(cyc - q0[0].acc + 1), 64'(q0[0].lat));
                end
                check("result0", 64'(res0), q0[0].res);
                check("flags0", 64'({fn0, fi0, fo0, fu0}), 64'(q0[0].fl));
                if (out_ready0) begin
                    void'(q0.pop_front());
                    trk0 = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            trk1 = 1'b0;
            q1.delete();
        end else if (out_valid1) begin
            if (q1.size() == 0) begin
                check("unexpected_out1", 64'(out_valid1), 64'd0);
            end else begin
                if (!trk1) begin
                    trk1 = 1'b1;
                    check("latency1", 64'(cyc - q1[0].acc + 1), 64'(q1[0].lat));
                end
                check("result1", 64'(res1), q1[0].res);
                check("flags1", 64'({fn1, fi1, fo1, fu1}), 64'(q1[0].fl));
                if (out_ready1) begin
                    void'(q1.pop_front());
                    trk1 = 1'b0;
                end
            end
        end
    end

    initial begin
        out_ready0 = 1'b1;
        out_ready1 = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready0 = (mode0 == 0) ? 1'b1 : (mode0 == 1) ? 1'($urandom) : 1'b0;
            out_ready1 = (mode1 == 0) ? 1'b1 : (mode1 == 1) ? 1'($urandom) : 1'b0;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
        $fatal(1);
    end

    logic [31:0] da[12], db[12], dr[12];
    logic [3:0]  df[12];
    int          dl[12];
    bit          seen;

    initial begin
        rst = 1'b1;
        in_valid0 = 1'b0; a0 = '0; b0 = '0;
        in_valid1 = 1'b0; a1 = '0; b1 = '0;
        da = '{32'h3FC00000, 32'hC0000000, 32'h3F800001, 32'h7F800000, 32'h7F000000, 32'h00800000,
               32'h3F800001, 32'h3F800002, 32'hFF800000, 32'h80000000, 32'h7FC01234, 32'h00400000};
        db = '{32'h40000000, 32'h40400000, 32'h3F800001, 32'h00000000, 32'h7F000000, 32'h00800000,
               32'h3FC00000, 32'h3FA00000, 32'h40000000, 32'h40400000, 32'h3F800000, 32'h3F800000};
        dr = '{32'h40400000, 32'hC0C00000, 32'h3F800002, 32'h7FC00000, 32'h7F800000, 32'h00000000,
               32'h3FC00002, 32'h3FA00002, 32'hFF800000, 32'h80000000, 32'h7FC00000, 32'h00000000};
        df = '{4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0110, 4'b0001,
               4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000};
        dl = '{26, 26, 26, 1, 26, 26, 26, 26, 1, 1, 1, 1};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready0", 64'(in_ready0), 64'd1);
        check("rst_out_valid0", 64'(out_valid0), 64'd0);
        check("rst_result0", 64'(res0), 64'd0);
        check("rst_flags0", 64'({fn0, fi0, fo0, fu0}), 64'd0);
        check("rst_in_ready1", 64'(in_ready1), 64'd1);
        check("rst_out_valid1", 64'(out_valid1), 64'd0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++) send0(da[i], db[i], 64'(dr[i]), df[i], dl[i]);
        drain(0);

        // Held result while the consumer stalls
        mode0 = 2;
        send0(32'h3FC00000, 32'h40000000, 64'h40400000, 4'b0000, 26);
        for (int n = 0; n < 100 && !out_valid0; n++) @(negedge clk);
        check("stall_reached_done", 64'(out_valid0), 64'd1);
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            check("stall_in_ready", 64'(in_ready0), 64'd0);
        end
        mode0 = 0;
        drain(0);

        // Abort in the middle of the multiply
        send0(32'h40000000, 32'h40000000, 64'h40800000, 4'b0000, 26);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_in_ready", 64'(in_ready0), 64'd1);
        seen = out_valid0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (out_valid0) seen = 1'b1;
        end
        check("abort_no_output", 64'(seen), 64'd0);
        @(posedge clk);
        #1;

        mode0 = 1;
        for (int i = 0; i < 150; i++) rsend0();
        drain(0);
        mode0 = 0;

        // Rounding carry-out renormalises: 1.4140625^2 rounds up to 2.0
        send1(16'h3DA8, 16'h3DA8, 64'h4000, 4'b0000, M1 + 3);
        drain(1);
        mode1 = 1;
        for (int i = 0; i < 150; i++) rsend1();
        drain(1);
        mode1 = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_mult_seq.md
FP_MULT_SEQ -- requirements
Module: fp_mult_seq

Interface
REQ-001 Parameter EXP_W, default 8: exponent field width.
REQ-002 Parameter MAN_W, default 23: stored mantissa (fraction) width; word width W = 1+EXP_W+MAN_W.
REQ-003 clk  input  1: single clock, all state on rising edge.
REQ-004 rst  input  1: synchronous, active-high reset.
REQ-005 in_valid  input  1: operands a, b valid.
REQ-006 in_ready  output  1: block can accept operands.
REQ-007 a, b  input  W each: IEEE-style operands {sign, exp, frac}.
REQ-008 out_valid  output  1: result and flags valid.
REQ-009 out_ready  input  1: consumer accepts result.
REQ-010 result  output  W: product.
REQ-011 f_nan, f_inf, f_ovf, f_unf  output  1 each: NaN result, infinite result, overflow occurred, underflow occurred.

Function
REQ-012 Operand transfer SHALL occur on a rising edge with in_valid&in_ready; result transfer on out_valid&out_ready.
REQ-013 FSM states SHALL be IDLE, MULT, ROUND, DONE; in_ready=1 only in IDLE.
REQ-014 IDLE->MULT on transfer of finite nonzero operands; IDLE->DONE on transfer when either operand is special (NaN, inf, zero/subnormal).
REQ-015 MULT SHALL run exactly MAN_W+1 cycles, one shift-add step of the (MAN_W+1)x(MAN_W+1) significand product per cycle, then go to ROUND.
REQ-016 ROUND SHALL last 1 cycle, then DONE; out_valid=1 only in DONE; DONE->IDLE on result transfer, otherwise result/flags held stable.
REQ-017 Latency: normal path out_valid rises MAN_W+3 edges after the accepting edge (26 at default); special path 1 edge.
REQ-018 Sign = a.sign XOR b.sign for every result except NaN.
REQ-019 Biased exponent SHALL be computed in EXP_W+2 signed bits: ea+eb-bias (bias = 2^(EXP_W-1)-1), +1 when product MSB set (normalise right by one).
REQ-020 Rounding SHALL be round-to-nearest-even using guard bit and OR-sticky of all lower bits; mantissa carry-out from rounding SHALL renormalise and increment exponent.
REQ-021 Subnormal inputs (exp=0) SHALL be treated as signed zero; subnormal results are not produced.
REQ-022 Final exponent >= all-ones: result = signed inf, f_inf=1, f_ovf=1.
REQ-023 Final exponent <= 0: result = signed zero, f_unf=1.
REQ-024 Any NaN input, or inf x zero: result = canonical NaN (sign 0, exp all ones, frac MSB 1, rest 0), f_nan=1.
REQ-025 inf x finite nonzero or inf x inf: signed inf, f_inf=1, f_ovf=0.
REQ-026 zero x finite: signed zero, all flags 0.
REQ-027 Flags SHALL be valid only with out_valid and cleared when a new operand is accepted.

Reset
REQ-028 On rst: state IDLE, in_ready=1, out_valid=0, result=0, all flags 0, multiplier accumulator and counter cleared.
REQ-029 rst asserted during MULT, ROUND or DONE SHALL abort the operation; no result emitted for it.
REQ-030 rst SHALL take priority over any simultaneous handshake.

Structure
REQ-031 Package fp_pkg SHALL hold the FSM state enum, default EXP_W/MAN_W, bias function, and canonical NaN/inf/zero encoding functions.
REQ-032 Sub-module seq_mantissa_multiplier (parameter N): start/busy/done, one-bit-per-cycle shift-add, 2N-bit product; fp_mult_seq instantiates it with N=MAN_W+1.
REQ-033 Expected RTL size 120-400 lines total.

Verification
REQ-034 a=0x3FC00000 (1.5), b=0x40000000 (2.0), out_ready=1 -> result 0x40400000, flags 0, out_valid 26 cycles after accept.
REQ-035 a=0xC0000000, b=0x40400000 -> 0xC0C00000; a=0x3F800001, b=0x3F800001 -> 0x3F800002 (below-half truncation).
REQ-036 a=0x7F800000, b=0x00000000 -> 0x7FC00000, f_nan=1, 1-cycle latency; a=0x7F000000, b=0x7F000000 -> 0x7F800000, f_inf=1, f_ovf=1.
REQ-037 a=0x00800000, b=0x00800000 -> 0x00000000, f_unf=1.
REQ-038 out_ready held 0 for 10 cycles in DONE -> result/flags stable, in_ready=0; rst pulsed mid-MULT -> out_valid stays 0, in_ready=1 next cycle.
REQ-039 Back-to-back random operands with random out_ready, EXP_W=5/MAN_W=10 and default -> match reference model bit-exactly.
